alu_issue_arbiter: RTL and testbench

- Issue queue and select arbiter in front of the two integer ALUs (ALU0, ALU1).
- Holds renamed ALU micro-ops until both physical source operands are ready, then dispatches up to two per cycle, oldest first.
- Tracks operand readiness from external writeback broadcasts and from its own issue grants, so a dependent op can issue back-to-back and pick up its operand through the ALU bypass network.
- Sits between dispatch/rename and the register-read stage of the ALU pipes.

---
 rtl/alu_issue_if.sv | 38 +++
 rtl/alu_issue_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Enqueue, writeback-broadcast and ALU0/ALU1 issue handshakes of the ALU issue queue.
// master = dispatch/writeback/ALU side, slave = alu_issue_arbiter.
interface alu_issue_if #(
    parameter int PADDR_W   = 6,
    parameter int PAYLOAD_W = 96
);
    logic                   enq_valid;
    logic                   enq_ready;
    logic [PAYLOAD_W-1:0]   enq_payload;
    logic [PADDR_W-1:0]     enq_src0_tag;
    logic                   enq_src0_rdy;
    logic [PADDR_W-1:0]     enq_src1_tag;
    logic                   enq_src1_rdy;
    logic [PADDR_W-1:0]     enq_dst_tag;
    logic                   enq_dst_we;
    logic [1:0]             wb_valid;
    logic [2*PADDR_W-1:0]   wb_tag;
    logic                   iss0_valid;
    logic                   iss0_ready;
    logic [PAYLOAD_W-1:0]   iss0_payload;
    logic                   iss1_valid;
    logic                   iss1_ready;
    logic [PAYLOAD_W-1:0]   iss1_payload;

    modport master (
        output enq_valid, enq_payload, enq_src0_tag, enq_src0_rdy, enq_src1_tag,
               enq_src1_rdy, enq_dst_tag, enq_dst_we, wb_valid, wb_tag,
               iss0_ready, iss1_ready,
        input  enq_ready, iss0_valid, iss0_payload, iss1_valid, iss1_payload
    );

    modport slave (
        input  enq_valid, enq_payload, enq_src0_tag, enq_src0_rdy, enq_src1_tag,
               enq_src1_rdy, enq_dst_tag, enq_dst_we, wb_valid, wb_tag,
               iss0_ready, iss1_ready,
        output enq_ready, iss0_valid, iss0_payload, iss1_valid, iss1_payload
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Dual-issue ALU issue queue: operand wakeup from writebacks and own grants, oldest-first select.
// Optional performance counters are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_arbiter #(
    parameter int DEPTH     = 8,
    parameter int PADDR_W   = 6,
    parameter int PAYLOAD_W = 96
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    alu_issue_if.slave              io,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [31:0]             perf_issue_cnt,
    output logic [31:0]             perf_full_cnt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam int NBC   = 4;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef logic [DEPTH-1:0] vec_t;

    vec_t                 valid_q, valid_d;
    vec_t                 src0_rdy_q, src0_rdy_d;
    vec_t                 src1_rdy_q, src1_rdy_d;
    vec_t                 dst_we_q, dst_we_d;
    vec_t                 older_q [DEPTH];
    vec_t                 older_d [DEPTH];
    logic [PADDR_W-1:0]   src0_tag_q [DEPTH];
    logic [PADDR_W-1:0]   src0_tag_d [DEPTH];
    logic [PADDR_W-1:0]   src1_tag_q [DEPTH];
    logic [PADDR_W-1:0]   src1_tag_d [DEPTH];
    logic [PADDR_W-1:0]   dst_tag_q [DEPTH];
    logic [PADDR_W-1:0]   dst_tag_d [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [OCC_W-1:0]     occ_q, occ_d;

    vec_t                 ready_vec, sel0_oh, sel1_oh, gnt0_oh, gnt1_oh;
    logic                 issue_en, enq_fire, gnt0, gnt1, gnt0_we, gnt1_we;
    logic [1:0]           n_gnt;
    logic [IDX_W-1:0]     free_idx;
    logic [PADDR_W-1:0]   gnt0_dst, gnt1_dst;
    logic [NBC-1:0]       bc_vld;
    logic [NBC*PADDR_W-1:0] bc_tag;

    function automatic logic tag_hit(input logic [PADDR_W-1:0] tag,
                                     input logic [NBC-1:0] vld,
                                     input logic [NBC*PADDR_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NBC; k++) begin
            if (vld[k] && (tags[k*PADDR_W +: PADDR_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // older[i] holds the set of entries enqueued before entry i.
    function automatic vec_t oldest(input vec_t cand, input vec_t older [DEPTH]);
        vec_t oh;
        oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cand[i] && ((older[i] & cand) == '0)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    assign io.enq_ready = ~rst & (occ_q < DEPTH_OCC);
    assign occupancy    = occ_q;

    always_comb begin
        issue_en        = ~rst & ~flush;
        ready_vec       = valid_q & src0_rdy_q & src1_rdy_q & {DEPTH{issue_en}};
        sel0_oh         = oldest(ready_vec, older_q);
        sel1_oh         = oldest(ready_vec & ~sel0_oh, older_q);
        io.iss0_valid   = |sel0_oh;
        io.iss1_valid   = |sel1_oh;
        io.iss0_payload = '0;
        io.iss1_payload = '0;
        gnt0_dst        = '0;
        gnt1_dst        = '0;
        gnt0_we         = 1'b0;
        gnt1_we         = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel0_oh[i]) begin
                io.iss0_payload = payload_q[i];
                gnt0_dst        = dst_tag_q[i];
                gnt0_we         = dst_we_q[i];
            end
            if (sel1_oh[i]) begin
                io.iss1_payload = payload_q[i];
                gnt1_dst        = dst_tag_q[i];
                gnt1_we         = dst_we_q[i];
            end
        end
        gnt0    = io.iss0_valid & io.iss0_ready;
        gnt1    = io.iss1_valid & io.iss1_ready;
        gnt0_oh = gnt0 ? sel0_oh : '0;
        gnt1_oh = gnt1 ? sel1_oh : '0;
        n_gnt   = {1'b0, gnt0} + {1'b0, gnt1};
        // Grants broadcast their destination at the same edge so dependents issue back-to-back.
        bc_vld  = {gnt1 & gnt1_we, gnt0 & gnt0_we, io.wb_valid};
        bc_tag  = {gnt1_dst, gnt0_dst, io.wb_tag};
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
        enq_fire   = io.enq_valid & io.enq_ready & ~flush;
        valid_d    = valid_q & ~(gnt0_oh | gnt1_oh);
        src0_rdy_d = src0_rdy_q;
        src1_rdy_d = src1_rdy_q;
        dst_we_d   = dst_we_q;
        older_d    = older_q;
        src0_tag_d = src0_tag_q;
        src1_tag_d = src1_tag_q;
        dst_tag_d  = dst_tag_q;
        payload_d  = payload_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (tag_hit(src0_tag_q[i], bc_vld, bc_tag)) src0_rdy_d[i] = 1'b1;
            if (tag_hit(src1_tag_q[i], bc_vld, bc_tag)) src1_rdy_d[i] = 1'b1;
        end
        if (enq_fire) begin
            valid_d[free_idx]    = 1'b1;
            src0_rdy_d[free_idx] = io.enq_src0_rdy | tag_hit(io.enq_src0_tag, bc_vld, bc_tag);
            src1_rdy_d[free_idx] = io.enq_src1_rdy | tag_hit(io.enq_src1_tag, bc_vld, bc_tag);
            dst_we_d[free_idx]   = io.enq_dst_we;
            src0_tag_d[free_idx] = io.enq_src0_tag;
            src1_tag_d[free_idx] = io.enq_src1_tag;
            dst_tag_d[free_idx]  = io.enq_dst_tag;
            payload_d[free_idx]  = io.enq_payload;
            for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = 1'b0;
            older_d[free_idx] = valid_q;
        end
        if (flush) valid_d = '0;
        occ_d = flush ? '0 : (occ_q + OCC_W'(enq_fire) - OCC_W'(n_gnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            src0_rdy_q <= '0;
            src1_rdy_q <= '0;
            occ_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            src0_rdy_q <= src0_rdy_d;
            src1_rdy_q <= src1_rdy_d;
            occ_q      <= occ_d;
        end
    end

    // Entry contents are qualified by valid_q and need no reset.
    always_ff @(posedge clk) begin
        dst_we_q   <= dst_we_d;
        older_q    <= older_d;
        src0_tag_q <= src0_tag_d;
        src1_tag_q <= src1_tag_d;
        dst_tag_q  <= dst_tag_d;
        payload_q  <= payload_d;
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d, perf_full_q, perf_full_d;

    always_comb begin
        perf_issue_d = perf_issue_q + 32'(n_gnt);
        perf_full_d  = perf_full_q + 32'(io.enq_valid & ~io.enq_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_full_q  <= '0;
        end else begin
            perf_issue_q <= perf_issue_d;
            perf_full_q  <= perf_full_d;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_full_cnt  = perf_full_q;
`else
    assign perf_issue_cnt = '0;
    assign perf_full_cnt  = '0;
`endif
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Random-stimulus bench for alu_issue_arbiter, checked cycle by cycle against an age-ordered list model.
module tb_alu_issue_arbiter;
    localparam int DEPTH     = 8;
    localparam int PADDR_W   = 6;
    localparam int PAYLOAD_W = 96;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  occupancy;
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_full_cnt;

    always #5 clk = ~clk;

    alu_issue_if #(.PADDR_W(PADDR_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    alu_issue_arbiter #(.DEPTH(DEPTH), .PADDR_W(PADDR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .io             (bus),
        .occupancy      (occupancy),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_full_cnt  (perf_full_cnt)
    );

    typedef struct {
        logic [PAYLOAD_W-1:0] pl;
        logic [PADDR_W-1:0]   t0;
        logic [PADDR_W-1:0]   t1;
        logic [PADDR_W-1:0]   dst;
        logic                 r0;
        logic                 r1;
        logic                 we;
    } ent_t;

    ent_t        mq[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          op_id    = 0;
    logic [31:0] exp_pi   = '0;
    logic [31:0] exp_pf   = '0;

    task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] got,
                       input logic [PAYLOAD_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_inputs(input int cyc);
        int phase, p_enq, p_rdy, p_wb, p_iss, tag_max;
        phase = cyc / 750;
        case (phase)
            0:       begin p_enq = 70;  p_rdy = 50; p_wb = 30; p_iss = 80; tag_max = 7; end
            1:       begin p_enq = 100; p_rdy = 0;  p_wb = 0;  p_iss = 60; tag_max = 7; end
            2:       begin p_enq = 80;  p_rdy = 30; p_wb = 10; p_iss = 90; tag_max = 3; end
            default: begin p_enq = 60;  p_rdy = 50; p_wb = 25; p_iss = 30; tag_max = 7; end
        endcase
        op_id++;
        bus.enq_valid    = ($urandom_range(0, 99) < p_enq);
        bus.enq_payload  = {32'($urandom), 32'($urandom), 32'(op_id)};
        bus.enq_src0_tag = PADDR_W'($urandom_range(0, tag_max));
        bus.enq_src0_rdy = ($urandom_range(0, 99) < p_rdy);
        bus.enq_src1_tag = PADDR_W'($urandom_range(0, tag_max));
        bus.enq_src1_rdy = ($urandom_range(0, 99) < p_rdy);
        bus.enq_dst_tag  = PADDR_W'($urandom_range(0, tag_max));
        bus.enq_dst_we   = ($urandom_range(0, 99) < 75);
        bus.wb_valid[0]  = ($urandom_range(0, 99) < p_wb);
        bus.wb_valid[1]  = ($urandom_range(0, 99) < p_wb);
        bus.wb_tag       = {PADDR_W'($urandom_range(0, tag_max)), PADDR_W'($urandom_range(0, tag_max))};
        bus.iss0_ready   = ($urandom_range(0, 99) < p_iss);
        bus.iss1_ready   = ($urandom_range(0, 99) < p_iss);
        flush            = (phase != 1) && ($urandom_range(0, 99) < 2);
        if (phase == 1) begin
            // Queue fills with ops waiting on tag 9 until a periodic writeback releases them.
            bus.enq_src0_tag = PADDR_W'(9);
            bus.enq_src1_rdy = 1'b1;
            bus.wb_valid     = 2'((cyc % 40) == 0);
            bus.wb_tag       = {PADDR_W'(0), PADDR_W'(9)};
        end
        if ((cyc % 113) == 60) flush = 1'b1;
    endtask

    task automatic model_step();
        int                 ri[$];
        logic [PADDR_W-1:0] bt[$];
        logic               exp_rdy, g0, g1;
        ent_t               e;
        exp_rdy = !rst && (mq.size() < DEPTH);
        if (!rst && !flush) begin
            foreach (mq[i]) if (mq[i].r0 && mq[i].r1 && ri.size() < 2) ri.push_back(i);
        end
        chk("iss0_valid", PAYLOAD_W'(bus.iss0_valid), PAYLOAD_W'(ri.size() > 0));
        chk("iss0_payload", bus.iss0_payload, (ri.size() > 0) ? mq[ri[0]].pl : '0);
        chk("iss1_valid", PAYLOAD_W'(bus.iss1_valid), PAYLOAD_W'(ri.size() > 1));
        chk("iss1_payload", bus.iss1_payload, (ri.size() > 1) ? mq[ri[1]].pl : '0);
        chk("occupancy", PAYLOAD_W'(occupancy), PAYLOAD_W'(mq.size()));
        chk("enq_ready", PAYLOAD_W'(bus.enq_ready), PAYLOAD_W'(exp_rdy));
        chk("perf_issue_cnt", PAYLOAD_W'(perf_issue_cnt), PAYLOAD_W'(exp_pi));
        chk("perf_full_cnt", PAYLOAD_W'(perf_full_cnt), PAYLOAD_W'(exp_pf));
        g0 = (ri.size() > 0) && bus.iss0_ready;
        g1 = (ri.size() > 1) && bus.iss1_ready;
        if (rst) begin
            mq.delete();
            exp_pi = '0;
            exp_pf = '0;
        end else begin
`ifdef ALU_ISSUE_PERF_EN
            exp_pi = exp_pi + 32'(g0) + 32'(g1);
            exp_pf = exp_pf + 32'(bus.enq_valid && !exp_rdy);
`endif
            if (flush) begin
                mq.delete();
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (bus.wb_valid[k]) bt.push_back(bus.wb_tag[k*PADDR_W +: PADDR_W]);
                end
                if (g0 && mq[ri[0]].we) bt.push_back(mq[ri[0]].dst);
                if (g1 && mq[ri[1]].we) bt.push_back(mq[ri[1]].dst);
                if (g1) mq.delete(ri[1]);
                if (g0) mq.delete(ri[0]);
                foreach (mq[i]) begin
                    e = mq[i];
                    foreach (bt[k]) begin
                        if (e.t0 == bt[k]) e.r0 = 1'b1;
                        if (e.t1 == bt[k]) e.r1 = 1'b1;
                    end
                    mq[i] = e;
                end
                if (bus.enq_valid && exp_rdy) begin
                    e.pl  = bus.enq_payload;
                    e.t0  = bus.enq_src0_tag;
                    e.t1  = bus.enq_src1_tag;
                    e.dst = bus.enq_dst_tag;
                    e.r0  = bus.enq_src0_rdy;
                    e.r1  = bus.enq_src1_rdy;
                    e.we  = bus.enq_dst_we;
                    foreach (bt[k]) begin
                        if (e.t0 == bt[k]) e.r0 = 1'b1;
                        if (e.t1 == bt[k]) e.r1 = 1'b1;
                    end
                    mq.push_back(e);
                end
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        flush            = 1'b0;
        bus.enq_valid    = 1'b0;
        bus.enq_payload  = '0;
        bus.enq_src0_tag = '0;
        bus.enq_src0_rdy = 1'b0;
        bus.enq_src1_tag = '0;
        bus.enq_src1_rdy = 1'b0;
        bus.enq_dst_tag  = '0;
        bus.enq_dst_we   = 1'b0;
        bus.wb_valid     = '0;
        bus.wb_tag       = '0;
        bus.iss0_ready   = 1'b0;
        bus.iss1_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = (cyc < 3) || (cyc >= 1750 && cyc < 1752);
            set_inputs(cyc);
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
